// File: rtl/d_mem_arb_pkg.sv
// Shared constants for the d_mem arbiter: FSM encoding, port indices and default memory depth.
package d_mem_arb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_ISSUE = 2'b01;
    localparam logic [1:0] ST_ACK   = 2'b10;

    localparam logic [0:0] PORT_CPU = 1'b0;
    localparam logic [0:0] PORT_DMA = 1'b1;

    localparam int unsigned D_MEM_RAM_SIZE_DEFAULT = 256;

endpackage

// File: rtl/d_mem_arbiter_chk.sv
// Protocol checker for d_mem_arbiter: exclusive one-cycle strobes and at most one ack per cycle.
module d_mem_arbiter_chk (
    input logic Clock,
    input logic Reset_n,
    input logic MemRead,
    input logic MemWrite,
    input logic Ack0,
    input logic Ack1
);

    a_strobe_excl: assert property (@(posedge Clock) disable iff (!Reset_n) !(MemRead && MemWrite));
    a_read_width:  assert property (@(posedge Clock) disable iff (!Reset_n) MemRead |=> !MemRead);
    a_write_width: assert property (@(posedge Clock) disable iff (!Reset_n) MemWrite |=> !MemWrite);
    a_one_ack:     assert property (@(posedge Clock) disable iff (!Reset_n) !(Ack0 && Ack1));

endmodule

// File: rtl/d_mem_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick; the port not granted last wins a tie.
module rr_arb2
    import d_mem_arb_pkg::*;
(
    input  logic Req0,
    input  logic Req1,
    input  logic LastGnt,
    output logic Gnt0,
    output logic Gnt1
);

    // Grant selection: a lone requester always wins, contention goes to the other port.
    always_comb begin
        Gnt0 = 1'b0;
        Gnt1 = 1'b0;
        if (Req0 && Req1) begin
            Gnt0 = (LastGnt == PORT_DMA[0]);
            Gnt1 = (LastGnt == PORT_CPU[0]);
        end else begin
            Gnt0 = Req0;
            Gnt1 = Req1;
        end
    end

endmodule

// File: rtl/d_mem_arbiter.sv
// Two-port arbiter in front of a single d_mem: IDLE -> ISSUE -> ACK, one transaction per 3 cycles.
// Optional macro D_MEM_ARB_BOUNDS_CHECK_EN enables the out-of-range check on the granted address.
module d_mem_arbiter
    import d_mem_arb_pkg::*;
#(
    parameter int unsigned RAM_SIZE  = D_MEM_RAM_SIZE_DEFAULT,
    parameter int unsigned NUM_PORTS = 2
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        Req0,
    input  logic        Req1,
    input  logic        We0,
    input  logic        We1,
    input  logic [31:0] Addr0,
    input  logic [31:0] Addr1,
    input  logic [31:0] WData0,
    input  logic [31:0] WData1,
    output logic        Ack0,
    output logic        Ack1,
    output logic [31:0] RData0,
    output logic [31:0] RData1,
    output logic        Err0,
    output logic        Err1,
    output logic [31:0] Address,
    output logic [31:0] WriteData,
    output logic        MemRead,
    output logic        MemWrite,
    input  logic [31:0] ReadData
);

    localparam int unsigned PORT_W = $clog2(NUM_PORTS);

`ifdef D_MEM_ARB_BOUNDS_CHECK_EN
    localparam logic BOUNDS_EN = 1'b1;
`else
    localparam logic BOUNDS_EN = 1'b0;
`endif

    logic [1:0]        state_q,     state_d;
    logic [PORT_W-1:0] gnt_q,       gnt_d;
    logic [PORT_W-1:0] last_gnt_q,  last_gnt_d;
    logic              we_q,        we_d;
    logic              oor_q,       oor_d;
    logic [31:0]       addr_q,      addr_d;
    logic [31:0]       wdata_q,     wdata_d;
    logic              mem_read_q,  mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic              ack0_q,      ack0_d;
    logic              ack1_q,      ack1_d;
    logic              err0_q,      err0_d;
    logic              err1_q,      err1_d;
    logic [31:0]       rdata0_q,    rdata0_d;
    logic [31:0]       rdata1_q,    rdata1_d;

    logic              gnt0_s;
    logic              gnt1_s;
    logic [31:0]       sel_addr_s;
    logic [31:0]       rd_val_s;

    rr_arb2 u_rr_arb2 (
        .Req0    (Req0),
        .Req1    (Req1),
        .LastGnt (last_gnt_q[0]),
        .Gnt0    (gnt0_s),
        .Gnt1    (gnt1_s)
    );

    // Next-state and datapath: requests are only looked at in IDLE.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_gnt_d  = last_gnt_q;
        we_d        = we_q;
        oor_d       = oor_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        err0_d      = 1'b0;
        err1_d      = 1'b0;
        sel_addr_s  = gnt1_s ? Addr1 : Addr0;
        rd_val_s    = (we_q || oor_q) ? 32'h0000_0000 : ReadData;
        case (state_q)
            ST_IDLE: begin
                if (gnt0_s || gnt1_s) begin
                    state_d     = ST_ISSUE;
                    gnt_d       = gnt1_s ? PORT_DMA : PORT_CPU;
                    last_gnt_d  = gnt_d;
                    we_d        = gnt1_s ? We1 : We0;
                    addr_d      = sel_addr_s;
                    wdata_d     = gnt1_s ? WData1 : WData0;
                    oor_d       = BOUNDS_EN && (sel_addr_s >= 32'(RAM_SIZE));
                    mem_write_d = we_d && !oor_d;
                    mem_read_d  = !we_d && !oor_d;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_ACK;
                if (gnt_q == PORT_DMA) begin
                    ack1_d   = 1'b1;
                    err1_d   = oor_q;
                    rdata1_d = rd_val_s;
                end else begin
                    ack0_d   = 1'b1;
                    err0_d   = oor_q;
                    rdata0_d = rd_val_s;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; LastGnt resets to port 1 so port 0 wins the first contention.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= ST_IDLE;
            gnt_q       <= PORT_CPU;
            last_gnt_q  <= PORT_DMA;
            we_q        <= 1'b0;
            oor_q       <= 1'b0;
            addr_q      <= 32'h0000_0000;
            wdata_q     <= 32'h0000_0000;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            err0_q      <= 1'b0;
            err1_q      <= 1'b0;
            rdata0_q    <= 32'h0000_0000;
            rdata1_q    <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_gnt_q  <= last_gnt_d;
            we_q        <= we_d;
            oor_q       <= oor_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            err0_q      <= err0_d;
            err1_q      <= err1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

    assign Address   = addr_q;
    assign WriteData = wdata_q;
    assign MemRead   = mem_read_q;
    assign MemWrite  = mem_write_q;
    assign Ack0      = ack0_q;
    assign Ack1      = ack1_q;
    assign Err0      = err0_q;
    assign Err1      = err1_q;
    assign RData0    = rdata0_q;
    assign RData1    = rdata1_q;

endmodule

// File: tb/tb_d_mem_arbiter.sv
// Directed bench for d_mem_arbiter with a behavioural d_mem; honours D_MEM_ARB_BOUNDS_CHECK_EN.
module tb_d_mem_arbiter;

    logic        Clock = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Req0 = 1'b0, Req1 = 1'b0, We0 = 1'b0, We1 = 1'b0;
    logic [31:0] Addr0 = 32'h0, Addr1 = 32'h0, WData0 = 32'h0, WData1 = 32'h0;
    logic        Ack0, Ack1, Err0, Err1, MemRead, MemWrite;
    logic [31:0] RData0, RData1, Address, WriteData, ReadData;
    logic [31:0] mem [0:255];

    int n_checks = 0;
    int n_pass   = 0;

`ifdef D_MEM_ARB_BOUNDS_CHECK_EN
    localparam logic BOUNDS_EN = 1'b1;
`else
    localparam logic BOUNDS_EN = 1'b0;
`endif

    always #5 Clock = ~Clock;

    d_mem_arbiter dut (
        .Clock(Clock), .Reset_n(Reset_n),
        .Req0(Req0), .Req1(Req1), .We0(We0), .We1(We1),
        .Addr0(Addr0), .Addr1(Addr1), .WData0(WData0), .WData1(WData1),
        .Ack0(Ack0), .Ack1(Ack1), .RData0(RData0), .RData1(RData1),
        .Err0(Err0), .Err1(Err1), .Address(Address), .WriteData(WriteData),
        .MemRead(MemRead), .MemWrite(MemWrite), .ReadData(ReadData)
    );

    d_mem_arbiter_chk u_chk (
        .Clock(Clock), .Reset_n(Reset_n), .MemRead(MemRead),
        .MemWrite(MemWrite), .Ack0(Ack0), .Ack1(Ack1)
    );

    // Behavioural d_mem: combinational read, write on the clock edge.
    assign ReadData = mem[Address[7:0]];
    always @(posedge Clock) begin
        if (MemWrite) mem[Address[7:0]] <= WriteData;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // One single-port transaction, checked in the ISSUE and ACK cycles.
    task automatic do_txn(input int port, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rd_exp,
                          input logic err_exp, input logic strobe_en);
        @(negedge Clock);
        if (port == 0) begin Req0 = 1'b1; We0 = we; Addr0 = addr; WData0 = wdata; end
        else           begin Req1 = 1'b1; We1 = we; Addr1 = addr; WData1 = wdata; end
        @(negedge Clock);
        check("issue_memwrite", {31'd0, MemWrite}, {31'd0, we & strobe_en});
        check("issue_memread",  {31'd0, MemRead},  {31'd0, ~we & strobe_en});
        check("issue_address",  Address, addr);
        if (we) check("issue_wdata", WriteData, wdata);
        check("issue_no_ack", {30'd0, Ack1, Ack0}, 32'd0);
        @(negedge Clock);
        check("ack_pulse", {30'd0, Ack1, Ack0}, (port == 0) ? 32'd1 : 32'd2);
        check("ack_strobes_low", {30'd0, MemRead, MemWrite}, 32'd0);
        check("ack_rdata", (port == 0) ? RData0 : RData1, rd_exp);
        check("ack_err", {31'd0, (port == 0) ? Err0 : Err1}, {31'd0, err_exp});
        Req0 = 1'b0;
        Req1 = 1'b0;
        @(negedge Clock);
        check("ack_one_cycle", {30'd0, Ack1, Ack0}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        repeat (2) @(negedge Clock);
        check("rst_outputs", {26'd0, Ack0, Ack1, Err0, Err1, MemRead, MemWrite}, 32'd0);
        check("rst_rdata", RData0 | RData1, 32'd0);
        check("rst_addr_wdata", Address | WriteData, 32'd0);
        Reset_n = 1'b1;

        // Write then read back through port 0; a write acks with RData0 = 0.
        do_txn(0, 1'b1, 32'd5, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
        do_txn(0, 1'b0, 32'd5, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
        // Port 1 write to the last word, read back on port 0.
        do_txn(1, 1'b1, 32'hFF, 32'h1234, 32'h0, 1'b0, 1'b1);
        do_txn(0, 1'b0, 32'hFF, 32'h0, 32'h1234, 1'b0, 1'b1);

        // Fresh reset, then continuous contention: grants 0,1,0,1 three cycles apart.
        @(negedge Clock);
        Reset_n = 1'b0;
        @(negedge Clock);
        Reset_n = 1'b1;
        Req0 = 1'b1; Req1 = 1'b1; We0 = 1'b0; We1 = 1'b0;
        Addr0 = 32'd5; Addr1 = 32'hFF;
        for (int i = 1; i <= 12; i++) begin
            @(negedge Clock);
            check("rr_ack0", {31'd0, Ack0}, {31'd0, (i == 2 || i == 8)});
            check("rr_ack1", {31'd0, Ack1}, {31'd0, (i == 5 || i == 11)});
            check("rr_memread", {31'd0, MemRead}, {31'd0, (i % 3 == 1)});
            if (i == 2 || i == 8)  check("rr_rdata0", RData0, 32'hDEADBEEF);
            if (i == 5 || i == 11) check("rr_rdata1", RData1, 32'h1234);
        end
        Req0 = 1'b0; Req1 = 1'b0;

        // Reset during ISSUE of a port-0 read: strobe drops at once, no ack, port 0 wins next.
        @(negedge Clock);
        @(negedge Clock);
        Req0 = 1'b1; We0 = 1'b0; Addr0 = 32'd5;
        @(negedge Clock);
        check("mid_issue_memread", {31'd0, MemRead}, 32'd1);
        #1 Reset_n = 1'b0;
        #1 check("async_drop_memread", {31'd0, MemRead}, 32'd0);
        Req0 = 1'b0;
        @(negedge Clock);
        check("reset_no_ack", {30'd0, Ack1, Ack0}, 32'd0);
        Reset_n = 1'b1;
        @(negedge Clock);
        Req0 = 1'b1; Req1 = 1'b1; Addr0 = 32'd5; Addr1 = 32'hFF;
        @(negedge Clock);
        check("post_rst_grant_addr", Address, 32'd5);
        @(negedge Clock);
        check("post_rst_ack", {30'd0, Ack1, Ack0}, 32'd1);
        check("post_rst_rdata0", RData0, 32'hDEADBEEF);
        Req0 = 1'b0; Req1 = 1'b0;
        @(negedge Clock);

        // Address 256: out of range only when the bounds check is built in (d_mem aliases it to word 0).
        do_txn(0, 1'b0, 32'd256, 32'h0, 32'h0, BOUNDS_EN, ~BOUNDS_EN);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/d_mem_arbiter.md
D_MEM_ARBITER -- requirements
Module: d_mem_arbiter

Interface
REQ-001 SHALL have parameter RAM_SIZE, default 256, number of 32-bit words in the attached d_mem.
REQ-002 SHALL have parameter NUM_PORTS, fixed at 2; port 0 = CPU load/store, port 1 = DMA/debug.
REQ-003 Clock  input  1  single clock; all state changes on its rising edge.
REQ-004 Reset_n  input  1  asynchronous, active-low reset.
REQ-005 Req0, Req1  input  1 each  request from port n; held high until AckN.
REQ-006 We0, We1  input  1 each  1 = write, 0 = read; stable while ReqN is high.
REQ-007 Addr0, Addr1  input  32 each  word address.
REQ-008 WData0, WData1  input  32 each  write data.
REQ-009 Ack0, Ack1  output  1 each  one-cycle completion pulse.
REQ-010 RData0, RData1  output  32 each  read data; valid only while AckN is high.
REQ-011 Err0, Err1  output  1 each  out-of-range flag; valid only while AckN is high.
REQ-012 Address, WriteData  output  32 each  driven to d_mem.
REQ-013 MemRead, MemWrite  output  1 each  registered strobes to d_mem.
REQ-014 ReadData  input  32  returned from d_mem.

Function
REQ-015 The FSM SHALL have states IDLE, ISSUE and ACK, with transitions IDLE->ISSUE when any ReqN is high, ISSUE->ACK always, and ACK->IDLE always.
REQ-016 In IDLE the block SHALL choose a winner and register GntPort, Address, WriteData and the direction.
REQ-017 In ISSUE the block SHALL hold exactly one of MemRead or MemWrite high for exactly one cycle.
REQ-018 The block SHALL latch ReadData into the winner's RData register at the end of ISSUE.
REQ-019 In ACK the block SHALL hold both strobes low, pulse AckN for the winner only, and drive RDataN from the latch.
REQ-020 A transaction SHALL complete with AckN high exactly 2 cycles after the edge that samples ReqN in IDLE.
REQ-021 Sustained throughput SHALL be 1 transaction per 3 cycles; no request SHALL be sampled in ISSUE or ACK.
REQ-022 The losing port SHALL wait with no change to its outputs.
REQ-023 With a single requester, that requester SHALL win.
REQ-024 With both requesters high, the port not granted last SHALL win (round-robin), and LastGnt SHALL update on every grant.
REQ-025 Strobes SHALL never be asserted in IDLE or ACK.
REQ-026 MemRead and MemWrite SHALL never be high together.
REQ-027 Address and WriteData SHALL be stable for the whole ISSUE cycle.
REQ-028 After a write, RDataN SHALL be 0.
REQ-029 ReqN dropping before AckN is a protocol violation; once a port is granted, the block SHALL still complete that transaction.

Reset
REQ-030 While Reset_n is low: state = IDLE, MemRead = MemWrite = 0, Ack0/1 = 0, Err0/1 = 0, RData0/1 = 0, Address = WriteData = 0, LastGnt = 1 (port 0 wins first contention).
REQ-031 Reset asserted mid-ISSUE SHALL drop the strobe immediately and issue no AckN; a write edge already delivered is not undone.

Configuration
REQ-032 With macro D_MEM_ARB_BOUNDS_CHECK_EN defined, a granted Addr >= RAM_SIZE SHALL skip the strobe in ISSUE and still go to ACK.
REQ-033 In that out-of-range case the ACK cycle SHALL pulse AckN with ErrN = 1 and RDataN = 0.
REQ-034 Without D_MEM_ARB_BOUNDS_CHECK_EN, no range check SHALL occur, Err0/1 SHALL be tied to 0, and the ports SHALL be unchanged.

Structure
REQ-035 Package d_mem_arb_pkg SHALL hold the FSM state encoding (IDLE = 2'b00, ISSUE = 2'b01, ACK = 2'b10), the port-index constants and the default RAM_SIZE.
REQ-036 Sub-module rr_arb2 SHALL implement the combinational 2-way round-robin pick (inputs Req0, Req1, LastGnt; outputs Gnt0, Gnt1).

Verification
REQ-037 Scenario: Req0 write Addr0 = 5, WData0 = 0xDEADBEEF, then Req0 read Addr0 = 5 -> MemWrite single pulse, then Ack0 with RData0 = 0xDEADBEEF, each Ack 2 cycles after sampling.
REQ-038 Scenario: Req0 and Req1 both reads, held continuously, first contention after reset -> grants alternate 0,1,0,1 and Ack pulses are 3 cycles apart.
REQ-039 Scenario: Req1 only, write Addr1 = 0xFF, WData1 = 0x1234 -> Ack1 only, Ack0 stays 0, and a later port-0 read of 0xFF returns 0x1234.
REQ-040 Scenario: Reset_n pulled low during ISSUE of a read -> MemRead falls asynchronously, no Ack, and the next grant goes to port 0.
REQ-041 Scenario (D_MEM_ARB_BOUNDS_CHECK_EN): Req0 read Addr0 = 256 -> no strobe, Ack0 = 1, Err0 = 1, RData0 = 0; without the macro, Err0 stays 0.
REQ-042 Checker: MemRead & MemWrite never both 1; strobe width is always 1 cycle; at most one AckN per cycle.
